// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem requests, IF/ID register with a one-entry skid.
// Define IF_STAGE_MISALIGN_CHK_EN to halt fetch on a misaligned redirect target and raise a sticky misalign flag.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        misalign
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

  // Handshakes: a request transfers in any cycle where imem_req_valid && imem_req_ready;
  // a response is the single cycle imem_rsp_valid is high; an IF/ID entry is consumed when id_valid && id_ready.
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        sk_valid_q, sk_valid_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_inst_q, sk_inst_d;
  logic        misalign_q, misalign_d;

  logic        req_hs;
  logic        rsp_take;
  logic        redir;
  logic        redir_bad;
  logic [31:0] redir_pc;

`ifdef IF_STAGE_MISALIGN_CHK_EN
  assign redir_pc  = redirect_pc;
  assign redir_bad = redirect_pc[1:0] != 2'b00;
`else
  assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
`endif

  assign imem_req_valid = (state_q == S_REQ) && !sk_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs   = imem_req_valid && imem_req_ready;
  assign rsp_take = (state_q == S_WAIT) && imem_rsp_valid;
  assign redir    = redirect_valid && (state_q != S_HALT);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    sk_valid_d = sk_valid_q;
    sk_pc_d    = sk_pc_q;
    sk_inst_d  = sk_inst_q;
    misalign_d = misalign_q;

    case (state_q)
      S_REQ: begin
        if (req_hs) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end
      S_WAIT:  if (imem_rsp_valid) state_d = S_REQ;
      S_DROP:  if (imem_rsp_valid) state_d = S_REQ;
      default: state_d = state_q;
    endcase

    // Consume first, then load; the skid refills IF/ID on the same edge it drains.
    if (id_valid_q && id_ready) begin
      if (sk_valid_q) begin
        id_pc_d    = sk_pc_q;
        id_inst_d  = sk_inst_q;
        sk_valid_d = 1'b0;
      end else begin
        id_valid_d = 1'b0;
      end
    end

    if (rsp_take) begin
      if ((!id_valid_q || id_ready) && !sk_valid_q) begin
        id_valid_d = 1'b1;
        id_pc_d    = req_pc_q;
        id_inst_d  = imem_rsp_data;
      end else begin
        sk_valid_d = 1'b1;
        sk_pc_d    = req_pc_q;
        sk_inst_d  = imem_rsp_data;
      end
    end

    // In S_DROP the IF/ID and skid are already empty, so flushing again only moves fetch_pc.
    if (redir) begin
      fetch_pc_d = redir_pc;
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      sk_valid_d = 1'b0;
      if (state_q != S_DROP) begin
        if (((state_q == S_WAIT) && !imem_rsp_valid) || req_hs) state_d = S_DROP;
        else                                                      state_d = S_REQ;
      end
      if (redir_bad) begin
        state_d    = S_HALT;
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= NOP_INST;
      sk_valid_q <= 1'b0;
      sk_pc_q    <= 32'h0;
      sk_inst_q  <= NOP_INST;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      sk_valid_q <= sk_valid_d;
      sk_pc_q    <= sk_pc_d;
      sk_inst_q  <= sk_inst_d;
      misalign_q <= misalign_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
`ifdef IF_STAGE_MISALIGN_CHK_EN
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule
